// File: rtl/snn_pkg.sv
// -----------------------------------------------------------------------------
// snn_pkg
// Shared types for the SNN run controller: the run-mode enum, the controller
// FSM state encoding, and a helper that maps the raw 2-bit mode input onto a
// run mode (the unused encoding 3 behaves as a single-sample run).
// -----------------------------------------------------------------------------
package snn_pkg;

    typedef enum logic [1:0] {
        SINGLE = 2'd0,
        BATCH  = 2'd1,
        CONT   = 2'd2
    } run_mode_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        SCAN  = 3'd3,
        DONE  = 3'd4
    } state_e;

    function automatic run_mode_e decode_mode(input logic [1:0] raw);
        case (raw)
            2'd1:    return BATCH;
            2'd2:    return CONT;
            default: return SINGLE;
        endcase
    endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset (count -> 0)
//   clr   : synchronous clear, dominates en
//   en    : count one event this cycle
//   count : current count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // NOTE: state is only ever updated with non-blocking assignments so every
    // flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/snn_run_ctrl.sv
// -----------------------------------------------------------------------------
// snn_run_ctrl
// Sequences inference runs of a spiking network: resets the network, enables
// it for sim_time timesteps, counts output spikes per output line, then scans
// the latched counts for the argmax (ties -> lowest index). Supports single,
// batch and continuous runs.
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   start, abort        : run request (IDLE/DONE only) / unconditional stop
//   mode, sim_time,
//   num_samples         : run configuration, latched at start
//   spike_out           : output-layer spikes from the network
//   network_rst/_en     : network control
//   busy, done          : status (done is sticky until the next start)
//   sample_valid        : one-cycle pulse per finished sample
//   sample_idx, winner,
//   spike_count         : results of the last finished sample
//   timestep            : live timestep counter
// -----------------------------------------------------------------------------
module snn_run_ctrl
    import snn_pkg::*;
#(
    parameter int NUM_OUTPUTS  = 4,
    parameter int COUNTER_SIZE = 32,
    parameter int TIME_WIDTH   = 32,
    parameter int REST_CYCLES  = 4
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    input  logic                                       abort,
    input  logic [1:0]                                 mode,
    input  logic [TIME_WIDTH-1:0]                      sim_time,
    input  logic [15:0]                                num_samples,
    input  logic [NUM_OUTPUTS-1:0]                     spike_out,
    output logic                                       network_rst,
    output logic                                       network_en,
    output logic                                       busy,
    output logic                                       done,
    output logic                                       sample_valid,
    output logic [15:0]                                sample_idx,
    output logic [$clog2(NUM_OUTPUTS)-1:0]             winner,
    output logic [NUM_OUTPUTS-1:0][COUNTER_SIZE-1:0]   spike_count,
    output logic [TIME_WIDTH-1:0]                      timestep
);

    localparam int IDX_W  = $clog2(NUM_OUTPUTS);
    localparam int REST_W = (REST_CYCLES > 1) ? $clog2(REST_CYCLES) : 1;

    state_e                                   state_q, state_d;
    run_mode_e                                mode_q, mode_d;
    logic [TIME_WIDTH-1:0]                    sim_time_q, sim_time_d;
    logic [15:0]                              num_samples_q, num_samples_d;
    logic [REST_W-1:0]                        rest_cnt_q, rest_cnt_d;
    logic [TIME_WIDTH-1:0]                    timestep_q, timestep_d;
    logic [15:0]                              cur_idx_q, cur_idx_d;
    logic [15:0]                              sample_idx_q, sample_idx_d;
    logic [IDX_W-1:0]                         scan_idx_q, scan_idx_d;
    logic [COUNTER_SIZE-1:0]                  best_val_q, best_val_d;
    logic [IDX_W-1:0]                         best_idx_q, best_idx_d;
    logic [IDX_W-1:0]                         winner_q, winner_d;
    logic [NUM_OUTPUTS-1:0][COUNTER_SIZE-1:0] spike_count_q, spike_count_d;
    logic                                     network_rst_q, network_rst_d;
    logic                                     network_en_q, network_en_d;
    logic                                     busy_q, busy_d;
    logic                                     done_q, done_d;
    logic                                     sample_valid_q, sample_valid_d;

    logic [NUM_OUTPUTS-1:0][COUNTER_SIZE-1:0] live_count;
    logic                                     live_clr;
    logic                                     go_clear;
    logic                                     abort_rst;
    logic [TIME_WIDTH-1:0]                    ts_next;
    logic [COUNTER_SIZE-1:0]                  cand_val;
    logic                                     take_new;
    logic [COUNTER_SIZE-1:0]                  new_best_val;
    logic [IDX_W-1:0]                         new_best_idx;

    // Live spike counters; the network only produces meaningful spikes while
    // it is enabled, so network_en gates every increment.
    assign live_clr = (state_q == CLEAR);

    for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_cnt
        sat_counter #(
            .WIDTH (COUNTER_SIZE)
        ) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .clr   (live_clr),
            .en    (network_en_q & spike_out[g]),
            .count (live_count[g])
        );
    end

    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d        = state_q;
        mode_d         = mode_q;
        sim_time_d     = sim_time_q;
        num_samples_d  = num_samples_q;
        rest_cnt_d     = rest_cnt_q;
        timestep_d     = timestep_q;
        cur_idx_d      = cur_idx_q;
        sample_idx_d   = sample_idx_q;
        scan_idx_d     = scan_idx_q;
        best_val_d     = best_val_q;
        best_idx_d     = best_idx_q;
        winner_d       = winner_q;
        spike_count_d  = spike_count_q;
        done_d         = done_q;
        network_en_d   = 1'b0;
        sample_valid_d = 1'b0;
        go_clear       = 1'b0;
        abort_rst      = 1'b0;
        ts_next        = timestep_q + TIME_WIDTH'(1);
        cand_val       = spike_count_q[scan_idx_q];
        take_new       = (scan_idx_q == '0) || (cand_val > best_val_q);
        new_best_val   = take_new ? cand_val : best_val_q;
        new_best_idx   = take_new ? scan_idx_q : best_idx_q;

        if (abort && (state_q != IDLE)) begin
            // Results, sample_idx and done stay as they were.
            state_d   = IDLE;
            abort_rst = 1'b1;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start && !abort) begin
                        mode_d        = decode_mode(mode);
                        sim_time_d    = sim_time;
                        num_samples_d = (num_samples == 16'd0) ? 16'd1 : num_samples;
                        done_d        = 1'b0;
                        sample_idx_d  = 16'd0;
                        cur_idx_d     = 16'd0;
                        go_clear      = 1'b1;
                    end
                end

                CLEAR: begin
                    if (rest_cnt_q == REST_W'(REST_CYCLES - 1)) begin
                        state_d      = RUN;
                        network_en_d = (sim_time_q != '0);
                    end else begin
                        rest_cnt_d = rest_cnt_q + REST_W'(1);
                    end
                end

                RUN: begin
                    // The cycle after the last enabled step is spent here with
                    // the network idle so the final increment has landed
                    // before the counts are copied out.
                    if (network_en_q) begin
                        timestep_d   = ts_next;
                        network_en_d = (ts_next < sim_time_q);
                    end else begin
                        spike_count_d = live_count;
                        scan_idx_d    = '0;
                        state_d       = SCAN;
                    end
                end

                SCAN: begin
                    best_val_d = new_best_val;
                    best_idx_d = new_best_idx;
                    if (scan_idx_q == IDX_W'(NUM_OUTPUTS - 1)) begin
                        winner_d       = new_best_idx;
                        sample_valid_d = 1'b1;
                        sample_idx_d   = cur_idx_q;
                        cur_idx_d      = cur_idx_q + 16'd1;
                        case (mode_q)
                            BATCH: begin
                                if (cur_idx_q == (num_samples_q - 16'd1)) begin
                                    state_d = DONE;
                                    done_d  = 1'b1;
                                end else begin
                                    go_clear = 1'b1;
                                end
                            end
                            CONT:    go_clear = 1'b1;
                            default: begin
                                state_d = DONE;
                                done_d  = 1'b1;
                            end
                        endcase
                    end else begin
                        scan_idx_d = scan_idx_q + IDX_W'(1);
                    end
                end

                default: state_d = IDLE;
            endcase
        end

        if (go_clear) begin
            state_d    = CLEAR;
            rest_cnt_d = '0;
            timestep_d = '0;
        end

        network_rst_d = (state_d == CLEAR) || abort_rst;
        busy_d        = (state_d == CLEAR) || (state_d == RUN) || (state_d == SCAN);
    end

    // NOTE: the result registers (spike_count, winner) are reset explicitly
    // because their reset value is visible on the ports.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            mode_q         <= SINGLE;
            sim_time_q     <= '0;
            num_samples_q  <= 16'd1;
            rest_cnt_q     <= '0;
            timestep_q     <= '0;
            cur_idx_q      <= 16'd0;
            sample_idx_q   <= 16'd0;
            scan_idx_q     <= '0;
            best_val_q     <= '0;
            best_idx_q     <= '0;
            winner_q       <= '0;
            spike_count_q  <= '0;
            network_rst_q  <= 1'b1;
            network_en_q   <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            sample_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            mode_q         <= mode_d;
            sim_time_q     <= sim_time_d;
            num_samples_q  <= num_samples_d;
            rest_cnt_q     <= rest_cnt_d;
            timestep_q     <= timestep_d;
            cur_idx_q      <= cur_idx_d;
            sample_idx_q   <= sample_idx_d;
            scan_idx_q     <= scan_idx_d;
            best_val_q     <= best_val_d;
            best_idx_q     <= best_idx_d;
            winner_q       <= winner_d;
            spike_count_q  <= spike_count_d;
            network_rst_q  <= network_rst_d;
            network_en_q   <= network_en_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            sample_valid_q <= sample_valid_d;
        end
    end

    assign network_rst  = network_rst_q;
    assign network_en   = network_en_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign sample_valid = sample_valid_q;
    assign sample_idx   = sample_idx_q;
    assign winner       = winner_q;
    assign spike_count  = spike_count_q;
    assign timestep     = timestep_q;

endmodule

// File: tb/tb_snn_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_snn_run_ctrl
// Drives two controllers in lockstep (32-bit and 4-bit spike counters). The
// bench plays the network: while network_en is high it presents a stored spike
// pattern step by step, and the expected counts/winner of each sample are
// computed from that pattern with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_snn_run_ctrl;

    localparam int NO   = 4;
    localparam int TW   = 32;
    localparam int REST = 4;
    localparam int MAXS = 8;
    localparam int MAXT = 40;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [1:0]        mode = 2'd0;
    logic [TW-1:0]     sim_time = '0;
    logic [15:0]       num_samples = 16'd0;
    logic [NO-1:0]     spike_out = '0;

    logic              network_rst, network_en, busy, done, sample_valid;
    logic [15:0]       sample_idx;
    logic [1:0]        winner;
    logic [NO-1:0][31:0] spike_count;
    logic [TW-1:0]     timestep;

    logic              s_network_rst, s_network_en, s_busy, s_done, s_sample_valid;
    logic [15:0]       s_sample_idx;
    logic [1:0]        s_winner;
    logic [NO-1:0][3:0] s_spike_count;
    logic [TW-1:0]     s_timestep;

    int errors = 0;
    int checks = 0;

    logic [NO-1:0] pat [MAXS][MAXT];

    snn_run_ctrl #(
        .NUM_OUTPUTS(NO), .COUNTER_SIZE(32), .TIME_WIDTH(TW), .REST_CYCLES(REST)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
        .sim_time(sim_time), .num_samples(num_samples), .spike_out(spike_out),
        .network_rst(network_rst), .network_en(network_en), .busy(busy),
        .done(done), .sample_valid(sample_valid), .sample_idx(sample_idx),
        .winner(winner), .spike_count(spike_count), .timestep(timestep)
    );

    snn_run_ctrl #(
        .NUM_OUTPUTS(NO), .COUNTER_SIZE(4), .TIME_WIDTH(TW), .REST_CYCLES(REST)
    ) dut_sat (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
        .sim_time(sim_time), .num_samples(num_samples), .spike_out(spike_out),
        .network_rst(s_network_rst), .network_en(s_network_en), .busy(s_busy),
        .done(s_done), .sample_valid(s_sample_valid), .sample_idx(s_sample_idx),
        .winner(s_winner), .spike_count(s_spike_count), .timestep(s_timestep)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Spikes of output i over the first st steps of sample s, saturated to w bits.
    function automatic longint exp_cnt(input int s, input int st, input int i, input int w);
        longint c   = 0;
        longint lim = (longint'(1) << w) - 1;
        for (int k = 0; k < st; k++) c += longint'(pat[s][k][i]);
        return (c > lim) ? lim : c;
    endfunction

    // First output with the strictly largest count.
    function automatic int exp_win(input int s, input int st, input int w);
        longint best = 0;
        int     idx  = 0;
        for (int i = 0; i < NO; i++) begin
            longint c = exp_cnt(s, st, i, w);
            if (i == 0 || c > best) begin
                best = c;
                idx  = i;
            end
        end
        return idx;
    endfunction

    task automatic fill_random();
        for (int s = 0; s < MAXS; s++)
            for (int k = 0; k < MAXT; k++) pat[s][k] = NO'($urandom);
    endtask

    task automatic fill_const(input logic [NO-1:0] v);
        for (int s = 0; s < MAXS; s++)
            for (int k = 0; k < MAXT; k++) pat[s][k] = v;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_net_rst"}, network_rst, 1);
        check({tag, "_net_en"}, network_en, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_valid"}, sample_valid, 0);
        check({tag, "_idx"}, sample_idx, 0);
        check({tag, "_winner"}, winner, 0);
        check({tag, "_timestep"}, timestep, 0);
        for (int i = 0; i < NO; i++) check({tag, "_count"}, spike_count[i], 0);
    endtask

    // One run: starts the controller, acts as the network, checks every
    // sample_valid against the pattern model. abort_s >= 0 aborts sample
    // abort_s after its third enabled step; poke >= 0 raises start mid-run.
    task automatic run_check(input logic [1:0] m, input int st, input int ns_in,
                             input int exp_samples, input int poke, input int abort_s);
        int s = 0, en_cnt = 0, rst_cnt = 0, cyc = 0;
        bit fin = 0, aborted = 0;
        @(negedge clk);
        start = 1'b1; mode = m; sim_time = TW'(st); num_samples = 16'(ns_in);
        @(negedge clk);
        start = 1'b0;
        while (!fin && !aborted && cyc < 3000) begin
            if (sample_valid) begin
                check("valid_idx", sample_idx, s);
                for (int i = 0; i < NO; i++) begin
                    check("count", spike_count[i], exp_cnt(s, st, i, 32));
                    check("sat_count", s_spike_count[i], exp_cnt(s, st, i, 4));
                end
                check("winner", winner, exp_win(s, st, 32));
                check("sat_winner", s_winner, exp_win(s, st, 4));
                check("en_cycles", en_cnt, st);
                check("rst_cycles", rst_cnt, REST);
                s++; en_cnt = 0; rst_cnt = 0;
            end
            if (network_rst) rst_cnt++;
            if (done) fin = 1;
            if (network_en) begin
                spike_out = (s < MAXS && en_cnt < MAXT) ? pat[s][en_cnt] : '1;
                en_cnt++;
                if (s == abort_s && en_cnt == 3) begin
                    abort   = 1'b1;
                    aborted = 1;
                end
            end else begin
                spike_out = NO'($urandom);
            end
            mode        = 2'($urandom);
            sim_time    = TW'($urandom_range(0, 50));
            num_samples = 16'($urandom);
            start       = (cyc == poke);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (aborted) begin
            abort = 1'b0;
            check("abort_busy", busy, 0);
            check("abort_net_rst", network_rst, 1);
            check("abort_net_en", network_en, 0);
            check("abort_valid", sample_valid, 0);
            check("abort_done", done, 0);
            check("abort_idx", sample_idx, abort_s - 1);
            check("abort_winner", winner, exp_win(abort_s - 1, st, 32));
            for (int i = 0; i < NO; i++)
                check("abort_count", spike_count[i], exp_cnt(abort_s - 1, st, i, 32));
            @(negedge clk);
            check("post_abort_net_rst", network_rst, 0);
            check("post_abort_busy", busy, 0);
            check("post_abort_valid", sample_valid, 0);
        end else begin
            check("run_finished", fin, 1);
            check("samples_done", s, exp_samples);
            check("done_busy", busy, 0);
            check("done_net_rst", network_rst, 0);
            check("done_timestep", timestep, st);
        end
        mode = 2'd0; sim_time = '0; num_samples = 16'd0; spike_out = '0;
    endtask

    initial begin
        // Reset state.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        @(negedge clk);
        check("idle_net_rst", network_rst, 0);
        check("idle_busy", busy, 0);

        // Single, sim_time=10, only output 2 spiking -> {0,0,10,0}, winner 2.
        fill_const(4'b0100);
        run_check(2'd0, 10, 5, 1, -1, -1);
        check("single_done", done, 1);
        check("single_count2", spike_count[2], 10);
        check("single_winner", winner, 2);

        // Batch of 3 with a start pulse while busy (ignored).
        fill_random();
        run_check(2'd1, 12, 3, 3, 6, -1);
        check("batch_done", done, 1);

        // Tie {5,7,7,1} -> winner 1.
        for (int k = 0; k < MAXT; k++)
            pat[0][k] = {k < 1, k < 7, k < 7, k < 5};
        run_check(2'd0, 8, 1, 1, -1, -1);
        check("tie_winner", winner, 1);

        // All-zero counts -> winner 0, mode 3 behaves as single.
        fill_const('0);
        run_check(2'd3, 6, 4, 1, -1, -1);
        check("zero_winner", winner, 0);

        // Saturation: 20 steps all high -> 4-bit counters stick at 15.
        fill_const('1);
        run_check(2'd0, 20, 1, 1, -1, -1);
        for (int i = 0; i < NO; i++) begin
            check("sat_15", s_spike_count[i], 15);
            check("nosat_20", spike_count[i], 20);
        end

        // sim_time = 0: no enable, counts zero, sample_valid still pulses.
        fill_const('1);
        run_check(2'd0, 0, 1, 1, -1, -1);
        // Batch with num_samples = 0 runs exactly one sample.
        fill_random();
        run_check(2'd1, 5, 0, 1, -1, -1);

        // Randomised batches.
        for (int r = 0; r < 3; r++) begin
            int ns = $urandom_range(1, 4);
            fill_random();
            run_check(2'd1, $urandom_range(1, 25), ns, ns, -1, -1);
        end

        // Continuous run aborted in the second sample's RUN phase.
        fill_random();
        run_check(2'd2, 8, 1, 0, -1, 1);

        // Abort together with start in IDLE: abort wins, nothing starts.
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("abort_start_busy", busy, 0);
        @(negedge clk);
        check("abort_start_busy2", busy, 0);

        // Reset in the middle of a run.
        @(negedge clk);
        start = 1'b1; mode = 2'd1; sim_time = 15; num_samples = 16'd4;
        @(negedge clk);
        start = 1'b0; spike_out = '1;
        repeat (8) @(negedge clk);
        check("pre_reset_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset("midrun_reset");
        rst = 1'b0;
        @(negedge clk);
        check("after_reset_net_rst", network_rst, 0);
        check("after_reset_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
